// File: rtl/lich_ngay_thang.sv
// lich_ngay_thang -- calendar date counter (day / month / year).
//
// Advances the date on each end_day pulse from the time-of-day chain,
// handling month lengths and Gregorian leap years (including the century
// rules). Button-driven setting of one field at a time, with the day clamped
// whenever a month or year change shortens the month.
//
// Ports
//   sig_1Hz    in   clock, all state changes on the rising edge
//   reset      in   asynchronous active-low reset
//   end_day    in   one-cycle pulse at 23:59:59 rollover
//   set_mode   in   0 run, 1 set day, 2 set month, 3 set year
//   inc_b      in   increment pulse for the selected field
//   day_o      out  day of month 1..31
//   month_o    out  month 1..12
//   year_o     out  binary year YEAR_BASE..YEAR_MAX
//   leap_o     out  current year is leap (combinational)
//   end_month  out  this end_day pulse closes the month (combinational)
//   end_year   out  this end_day pulse closes the year (combinational)
module lich_ngay_thang #(
  parameter int YEAR_W    = 12,
  parameter int YEAR_BASE = 2000,
  parameter int YEAR_MAX  = 2199
) (
  input  logic              sig_1Hz,
  input  logic              reset,
  input  logic              end_day,
  input  logic [1:0]        set_mode,
  input  logic              inc_b,
  output logic [4:0]        day_o,
  output logic [3:0]        month_o,
  output logic [YEAR_W-1:0] year_o,
  output logic              leap_o,
  output logic              end_month,
  output logic              end_year
);

  localparam logic [YEAR_W-1:0] Y_BASE = YEAR_BASE[YEAR_W-1:0];
  localparam logic [YEAR_W-1:0] Y_MAX  = YEAR_MAX[YEAR_W-1:0];
  localparam logic [YEAR_W-1:0] Y_100  = YEAR_W'(100);
  localparam logic [YEAR_W-1:0] Y_400  = YEAR_W'(400);

  function automatic logic is_leap(input logic [YEAR_W-1:0] y);
    is_leap = (y[1:0] == 2'd0) && (((y % Y_100) != '0) || ((y % Y_400) == '0));
  endfunction

  function automatic logic [4:0] dim(input logic [3:0] m, input logic leap);
    case (m)
      4'd2:                      dim = leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   dim = 5'd30;
      default:                   dim = 5'd31;
    endcase
  endfunction

  logic [4:0]        day_q, day_d;
  logic [3:0]        month_q, month_d;
  logic [YEAR_W-1:0] year_q, year_d;

  logic              leap_cur;
  logic [4:0]        dim_cur;
  logic              last_day;
  logic [3:0]        month_nxt;
  logic [YEAR_W-1:0] year_nxt;
  logic [4:0]        dim_new_m;   // month length after a month step
  logic [4:0]        dim_new_y;   // month length after a year step

  always_comb begin
    leap_cur  = is_leap(year_q);
    dim_cur   = dim(month_q, leap_cur);
    last_day  = (day_q == dim_cur);
    month_nxt = (month_q == 4'd12) ? 4'd1 : month_q + 4'd1;
    year_nxt  = (year_q == Y_MAX) ? Y_BASE : year_q + YEAR_W'(1);
    // Feb only shortens when the year changes; other months are unaffected.
    dim_new_m = dim(month_nxt, leap_cur);
    dim_new_y = dim(month_q, is_leap(year_nxt));

    day_d   = day_q;
    month_d = month_q;
    year_d  = year_q;

    // Compare first, then increment: registers never see out-of-range values.
    case (set_mode)
      2'd0: if (end_day) begin
        if (!last_day) begin
          day_d = day_q + 5'd1;
        end else begin
          day_d   = 5'd1;
          month_d = month_nxt;
          if (month_q == 4'd12) year_d = year_nxt;
        end
      end
      2'd1: if (inc_b) day_d = last_day ? 5'd1 : day_q + 5'd1;
      2'd2: if (inc_b) begin
        month_d = month_nxt;
        day_d   = (day_q > dim_new_m) ? dim_new_m : day_q;
      end
      default: if (inc_b) begin
        year_d = year_nxt;
        day_d  = (day_q > dim_new_y) ? dim_new_y : day_q;
      end
    endcase

    // Gated by reset so the pulses stay low while the counter is held.
    end_month = reset & end_day & (set_mode == 2'd0) & last_day;
    end_year  = end_month & (month_q == 4'd12);
  end

  always_ff @(posedge sig_1Hz or negedge reset) begin
    if (!reset) begin
      day_q   <= 5'd1;
      month_q <= 4'd1;
      year_q  <= Y_BASE;
    end else begin
      day_q   <= day_d;
      month_q <= month_d;
      year_q  <= year_d;
    end
  end

  assign day_o   = day_q;
  assign month_o = month_q;
  assign year_o  = year_q;
  assign leap_o  = leap_cur;

endmodule

// File: tb/tb_lich_ngay_thang.sv
// Self-checking bench for lich_ngay_thang: directed calendar scenarios plus
// randomized operations against a plain-arithmetic calendar model.
module tb_lich_ngay_thang;

  localparam int YEAR_W    = 12;
  localparam int YEAR_BASE = 2000;
  localparam int YEAR_MAX  = 2199;

  logic              sig_1Hz;
  logic              reset;
  logic              end_day;
  logic [1:0]        set_mode;
  logic              inc_b;
  logic [4:0]        day_o;
  logic [3:0]        month_o;
  logic [YEAR_W-1:0] year_o;
  logic              leap_o;
  logic              end_month;
  logic              end_year;

  lich_ngay_thang #(.YEAR_W(YEAR_W), .YEAR_BASE(YEAR_BASE), .YEAR_MAX(YEAR_MAX)) dut (
    .sig_1Hz  (sig_1Hz),
    .reset    (reset),
    .end_day  (end_day),
    .set_mode (set_mode),
    .inc_b    (inc_b),
    .day_o    (day_o),
    .month_o  (month_o),
    .year_o   (year_o),
    .leap_o   (leap_o),
    .end_month(end_month),
    .end_year (end_year)
  );

  initial sig_1Hz = 1'b0;
  always #5 sig_1Hz = ~sig_1Hz;

  int checks = 0;
  int errors = 0;

  // Reference calendar state
  int md, mm, my;
  int month_len [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

  function automatic int mleap(input int y);
    return ((y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0))) ? 1 : 0;
  endfunction

  function automatic int mdim(input int m, input int y);
    return month_len[m-1] + ((m == 2) ? mleap(y) : 0);
  endfunction

  function automatic int next_year(input int y);
    return (y == YEAR_MAX) ? YEAR_BASE : y + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_date(input string tag);
    chk({tag, "_day"},   32'(day_o),   32'(md));
    chk({tag, "_month"}, 32'(month_o), 32'(mm));
    chk({tag, "_year"},  32'(year_o),  32'(my));
    chk({tag, "_leap"},  32'(leap_o),  32'(mleap(my)));
  endtask

  // One cycle: drive on negedge, check combinational pulses before the edge,
  // advance the model on the edge, check registers after it.
  task automatic step(input bit ed, input bit ib, input logic [1:0] mode);
    int exp_em, exp_ey;
    @(negedge sig_1Hz);
    end_day = ed; inc_b = ib; set_mode = mode;
    #1;
    exp_em = (ed && mode == 2'd0 && md == mdim(mm, my)) ? 1 : 0;
    exp_ey = (exp_em == 1 && mm == 12) ? 1 : 0;
    chk("end_month", 32'(end_month), 32'(exp_em));
    chk("end_year",  32'(end_year),  32'(exp_ey));
    @(posedge sig_1Hz);
    if (mode == 2'd0) begin
      if (ed) begin
        md++;
        if (md > mdim(mm, my)) begin
          md = 1; mm++;
          if (mm > 12) begin mm = 1; my = next_year(my); end
        end
      end
    end else if (ib) begin
      case (mode)
        2'd1: md = (md == mdim(mm, my)) ? 1 : md + 1;
        2'd2: begin mm = mm % 12 + 1; if (md > mdim(mm, my)) md = mdim(mm, my); end
        default: begin my = next_year(my); if (md > mdim(mm, my)) md = mdim(mm, my); end
      endcase
    end
    #1;
    chk_date("step");
    end_day = 1'b0; inc_b = 1'b0;
  endtask

  // Walk to a date through the set modes (year, then month, then day).
  task automatic goto_date(input int d, input int m, input int y);
    while (my != y) step(1'b0, 1'b1, 2'd3);
    while (mm != m) step(1'b0, 1'b1, 2'd2);
    while (md != d) step(1'b0, 1'b1, 2'd1);
  endtask

  initial begin
    reset = 1'b0; end_day = 1'b0; inc_b = 1'b0; set_mode = 2'd0;
    md = 1; mm = 1; my = YEAR_BASE;
    repeat (2) @(posedge sig_1Hz);
    @(negedge sig_1Hz); reset = 1'b1;
    #1;
    chk("rst_day", 32'(day_o), 32'd1);
    chk("rst_month", 32'(month_o), 32'd1);
    chk("rst_year", 32'(year_o), 32'd2000);
    chk("rst_leap2000", 32'(leap_o), 32'd1);
    chk("rst_em", 32'(end_month), 32'd0);
    chk("rst_ey", 32'(end_year), 32'd0);

    // Month rollover
    goto_date(31, 1, 2023);
    step(1'b1, 1'b0, 2'd0);
    chk("jan_roll_day", 32'(day_o), 32'd1);
    chk("jan_roll_month", 32'(month_o), 32'd2);
    goto_date(28, 2, 2023);
    step(1'b1, 1'b0, 2'd0);
    chk("feb23_roll_month", 32'(month_o), 32'd3);

    // Leap years
    goto_date(28, 2, 2024);
    step(1'b1, 1'b0, 2'd0);
    chk("leap24_day29", 32'(day_o), 32'd29);
    step(1'b1, 1'b0, 2'd0);
    chk("leap24_mar1", 32'(month_o), 32'd3);
    goto_date(28, 2, 2100);
    step(1'b1, 1'b0, 2'd0);
    chk("y2100_mar", 32'(month_o), 32'd3);
    chk("y2100_noleap", 32'(leap_o), 32'd0);

    // Year rollover and wrap
    goto_date(31, 12, 2199);
    @(negedge sig_1Hz); #1;
    step(1'b1, 1'b0, 2'd0);
    chk("wrap_year", 32'(year_o), 32'd2000);
    chk("wrap_day", 32'(day_o), 32'd1);

    // Set mode clamps
    goto_date(31, 3, 2023);
    step(1'b0, 1'b1, 2'd2);
    chk("clamp_apr30", 32'(day_o), 32'd30);
    goto_date(29, 2, 2024);
    step(1'b0, 1'b1, 2'd3);
    chk("clamp_feb28", 32'(day_o), 32'd28);
    chk("clamp_2025", 32'(year_o), 32'd2025);
    goto_date(30, 4, 2025);
    step(1'b0, 1'b1, 2'd1);
    chk("setday_wrap", 32'(day_o), 32'd1);
    chk("setday_month", 32'(month_o), 32'd4);

    // Conflicts
    goto_date(30, 4, 2025);
    step(1'b1, 1'b1, 2'd1);
    chk("conf_day", 32'(day_o), 32'd1);
    chk("conf_month", 32'(month_o), 32'd4);
    step(1'b0, 1'b1, 2'd0);
    chk("run_incb_ignored", 32'(day_o), 32'd1);

    // Asynchronous reset mid-count while a qualifying end_day is applied
    goto_date(31, 12, 2030);
    @(negedge sig_1Hz);
    end_day = 1'b1; set_mode = 2'd1;
    set_mode = 2'd0;
    #1;
    chk("pre_rst_ey", 32'(end_year), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("async_rst_day", 32'(day_o), 32'd1);
    chk("async_rst_month", 32'(month_o), 32'd1);
    chk("async_rst_year", 32'(year_o), 32'd2000);
    chk("async_rst_em", 32'(end_month), 32'd0);
    chk("async_rst_ey", 32'(end_year), 32'd0);
    @(negedge sig_1Hz);
    end_day = 1'b0; reset = 1'b1;
    md = 1; mm = 1; my = YEAR_BASE;
    step(1'b0, 1'b0, 2'd0);

    // Randomized operations against the model
    for (int i = 0; i < 600; i++) begin
      logic [1:0] mode;
      mode = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), mode);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
